// File: rtl/fb_pattern_pkg.sv
// fb_pattern_pkg: shared encodings and bar palette for the framebuffer pattern writer
package fb_pattern_pkg;
    typedef enum logic [1:0] {MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD} mode_e;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
    localparam logic [7:0] BAR_PALETTE [8] = '{8'hE0, 8'h1C, 8'h03, 8'hFF, 8'hFC, 8'h1F, 8'hE3, 8'h00};
endpackage

// File: rtl/fb_scan_counter.sv
// fb_scan_counter: raster x/y/address walker with a divider-free per-line bar index
module fb_scan_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 400,
    parameter int ADDR_W   = 32,
    parameter int NUM_BARS = 3
) (
    input  logic                        pclk,
    input  logic                        rst_n,
    input  logic                        i_advance,
    input  logic                        i_clear,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [2:0]                  o_bar_idx,
    output logic                        o_last_col,
    output logic                        o_last_pixel
);
    localparam int X_W   = $clog2(H_ACTIVE);
    localparam int Y_W   = $clog2(V_ACTIVE);
    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    logic [X_W-1:0]    r_x, r_bar_cnt;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_bar_idx;
    logic              w_bar_end;

    // the last bar never ends early, so it soaks up the H_ACTIVE % NUM_BARS remainder
    assign w_bar_end    = r_bar_cnt == X_W'(BAR_W - 1) && r_bar_idx != 3'(NUM_BARS - 1);
    assign o_last_col   = r_x == X_W'(H_ACTIVE - 1);
    assign o_last_pixel = o_last_col && r_y == Y_W'(V_ACTIVE - 1);
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_addr       = r_addr;
    assign o_bar_idx    = r_bar_idx;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n || i_clear) begin
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (i_advance) begin
            r_x       <= o_last_col ? '0 : r_x + 1'b1;
            r_y       <= o_last_pixel ? '0 : o_last_col ? r_y + 1'b1 : r_y;
            r_addr    <= o_last_pixel ? '0 : r_addr + 1'b1;
            r_bar_cnt <= (o_last_col || w_bar_end) ? '0 : r_bar_cnt + 1'b1;
            r_bar_idx <= o_last_col ? '0 : r_bar_idx + 3'(w_bar_end);
        end
    end
endmodule

// File: rtl/fb_pattern_gen.sv
// fb_pattern_gen: streams one frame of test-pattern pixels into the framebuffer write port
module fb_pattern_gen
    import fb_pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 400,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int NUM_BARS    = 3,
    parameter int CHECK_SHIFT = 5
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_restart,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);
    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);

    state_e            r_state, w_next;
    mode_e             r_mode;
    logic [DATA_W-1:0] r_color, w_pix;
    logic [15:0]       r_frame_cnt;
    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;
    logic [2:0]        w_bar_idx;
    logic              w_advance, w_latch, w_last_col, w_last_pixel, w_frame_end, w_chk;

    assign w_advance   = r_state == FILL && wr_ready;
    assign w_frame_end = w_advance && w_last_col && w_last_pixel;
    assign w_latch     = (r_state == IDLE && start) || (r_state == DONE && auto_restart);
    assign frame_cnt   = r_frame_cnt;

    fb_scan_counter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .ADDR_W  (ADDR_W),
        .NUM_BARS(NUM_BARS)
    ) u_scan (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .i_advance   (w_advance),
        .i_clear     (r_state != FILL),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_addr      (wr_addr),
        .o_bar_idx   (w_bar_idx),
        .o_last_col  (w_last_col),
        .o_last_pixel(w_last_pixel)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (start ? FILL : IDLE)
               : r_state == FILL ? (w_frame_end ? DONE : FILL)
               : (auto_restart ? FILL : IDLE);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_SOLID;
            r_color     <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_mode  <= mode_e'(mode);
                r_color <= fill_color;
            end
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_chk = (((32'(w_x) ^ 32'(w_y)) >> CHECK_SHIFT) & 32'd1) != 32'd0;
    assign w_pix = r_mode == MODE_SOLID ? r_color
                 : r_mode == MODE_BARS  ? DATA_W'(BAR_PALETTE[w_bar_idx])
                 : r_mode == MODE_CHECK ? (w_chk ? ~r_color : r_color)
                 : DATA_W'(w_x);

    always_comb begin
        wr_en   = r_state == FILL;
        busy    = r_state == FILL;
        done    = r_state == DONE;
        wr_data = wr_en ? w_pix : '0;
    end
endmodule

// File: tb/tb_fb_pattern_gen.sv
// tb_fb_pattern_gen: randomized-handshake bench against a per-pixel arithmetic reference model
module tb_fb_pattern_gen;
    localparam int H = 264, V = 33, NB = 5, CS = 5, NPIX = H * V, LIM = 40000;
    localparam logic [7:0] PAL [8] = '{8'hE0, 8'h1C, 8'h03, 8'hFF, 8'hFC, 8'h1F, 8'hE3, 8'h00};

    logic        pclk = 0, rst_n = 0, start = 0, auto_restart = 0, wr_ready = 1;
    logic [1:0]  mode = 0;
    logic [7:0]  fill_color = 0;
    logic        wr_en, busy, done;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] frame_cnt;

    int n_chk = 0, n_err = 0, rdy_pct = 100;
    int cyc = 0, n_acc = 0, n_done = 0, t_first = 0, t_done = 0, exp_addr = 0;
    bit m_busy = 0, m_done = 0;
    logic [15:0] m_cnt = 0;
    logic [1:0]  f_mode = 0;
    logic [7:0]  f_color = 0;
    logic [7:0]  mem [NPIX];

    fb_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(32), .DATA_W(8), .NUM_BARS(NB), .CHECK_SHIFT(CS)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .auto_restart(auto_restart), .mode(mode),
        .fill_color(fill_color), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic [1:0] m, input logic [7:0] c, input int a);
        int x = a % H, y = a / H, b;
        case (m)
            2'd0: return c;
            2'd1: begin
                b = x / (H / NB);
                if (b > NB - 1) b = NB - 1;
                return PAL[b];
            end
            2'd2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? ~c : c;
            default: return 8'(x % 256);
        endcase
    endfunction

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic monitor;
        bit nd;
        forever begin
            @(negedge pclk);
            cyc++;
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_cnt = 0; exp_addr = 0;
            end else begin
                check("wr_en", wr_en, m_busy);
                check("busy", busy, m_busy);
                check("done", done, m_done);
                check("frame_cnt", frame_cnt, m_cnt);
                if (m_busy) begin
                    check("addr", wr_addr, exp_addr);
                    check("data", wr_data, ref_pix(f_mode, f_color, exp_addr));
                end
                nd = 0;
                if (m_busy) begin
                    if (wr_ready) begin
                        mem[exp_addr] = wr_data;
                        if (exp_addr == 0) t_first = cyc;
                        n_acc++;
                        if (exp_addr == NPIX - 1) begin
                            m_busy = 0; nd = 1; m_cnt = m_cnt + 16'd1; exp_addr = 0;
                        end else exp_addr++;
                    end
                end else if (m_done) begin
                    if (auto_restart) begin m_busy = 1; f_mode = mode; f_color = fill_color; end
                end else if (start) begin
                    m_busy = 1; f_mode = mode; f_color = fill_color;
                end
                if (m_done) begin n_done++; t_done = cyc; end
                m_done = nd;
            end
        end
    endtask

    task automatic ready_drv;
        forever begin
            @(posedge pclk);
            #1 wr_ready = $urandom_range(99) < rdy_pct;
        end
    endtask

    task automatic wait_done;
        int n0 = n_done, t = 0;
        while (n_done == n0 && t < LIM) begin tick; t++; end
        check("frame_timeout", n_done != n0, 1);
    endtask

    task automatic kick(input logic [1:0] m, input logic [7:0] c);
        mode = m; fill_color = c; start = 1;
        tick;
        start = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        tick;
        rst_n = 1;
        tick;
    endtask

    initial begin
        int t;
        fork
            monitor;
            ready_drv;
        join_none
        repeat (3) tick;
        check("reset_wr_en", wr_en, 0);
        check("reset_addr", wr_addr, 0);
        check("reset_data", wr_data, 0);
        check("reset_done", done, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        rst_n = 1;
        tick;

        // bars, full throughput, with an ignored start and a mid-frame mode change
        n_acc = 0;
        kick(2'd1, 8'h00);
        repeat (100) tick;
        mode = 2'd0; start = 1;
        tick;
        start = 0;
        wait_done;
        check("t1_writes", n_acc, NPIX);
        check("t1_done_lat", t_done - t_first, NPIX);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_px0", mem[0], 8'hE0);
        check("t1_px51", mem[51], 8'hE0);
        check("t1_px52", mem[52], 8'h1C);
        check("t1_px104", mem[104], 8'h03);
        check("t1_px156", mem[156], 8'hFF);
        check("t1_px263", mem[263], 8'hFC);
        check("t1_px264", mem[264], 8'hE0);
        repeat (5) tick;
        check("t1_idle", wr_en, 0);

        // solid colour under random back-pressure
        rdy_pct = 50; n_acc = 0;
        kick(2'd0, 8'h5A);
        wait_done;
        check("t2_writes", n_acc, NPIX);
        check("t2_last", mem[NPIX-1], 8'h5A);
        rdy_pct = 100;

        kick(2'd2, 8'hF0);
        wait_done;
        check("t3_0_0", mem[0], 8'hF0);
        check("t3_32_0", mem[32], 8'h0F);
        check("t3_32_32", mem[32*H+32], 8'hF0);
        check("t3_31_32", mem[32*H+31], 8'h0F);

        kick(2'd3, 8'h00);
        wait_done;
        check("t4_255", mem[255], 8'hFF);
        check("t4_256", mem[256], 8'h00);
        check("t4_263", mem[263], 8'h07);
        check("t4_264", mem[H], 8'h00);

        // back-to-back frames, mode changed during frame 2 takes effect on frame 3
        do_reset;
        auto_restart = 1;
        kick(2'd1, 8'h00);
        wait_done;
        repeat (100) tick;
        mode = 2'd0; fill_color = 8'h33;
        wait_done;
        auto_restart = 0;
        wait_done;
        check("t5_frame_cnt", frame_cnt, 3);
        check("t5_px0", mem[0], 8'h33);
        check("t5_last", mem[NPIX-1], 8'h33);

        // abort mid-frame and restart from address 0
        rdy_pct = 70;
        kick(2'd1, 8'h00);
        t = 0;
        while (exp_addr < 1000 && t < LIM) begin tick; t++; end
        check("t6_reach", exp_addr >= 1000, 1);
        do_reset;
        check("t6_idle", wr_en, 0);
        kick(2'd3, 8'h00);
        check("t6_wr_en", wr_en, 1);
        check("t6_addr", wr_addr, 0);
        repeat (20) tick;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
